rvpipe_elastic: RTL and testbench

//  Parametrised elastic pipeline register: successor to the fixed-width reset-to-zero flop bank.

---
 rtl/rvpipe_pkg.sv | 15 +
 rtl/rvpipe_stage.sv | 44 ++++
 rtl/rvpipe_elastic.sv | 111 +++++++++++
 tb/tb_rvpipe_elastic.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rvpipe_pkg.sv
// rvpipe_pkg: shared types and helpers for the rvpipe elastic pipeline.
package rvpipe_pkg;

    // Per-stage control bits used to build the move chain.
    typedef struct packed {
        logic v;   // stage holds a valid entry
        logic mv;  // stage hands its entry downstream this cycle
    } stage_ctl_t;

    // Width needed to hold an occupancy count of 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rvpipe_stage.sv
// rvpipe_stage: one register slot of the elastic pipe (valid, payload and,
// with RVPIPE_PARITY_EN defined, a stored parity bit).
module rvpipe_stage
    import rvpipe_pkg::*;
#(
    parameter int WIDTH = 63
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             flush,
    input  logic             ld,     // slot is empty or moving: take v_in
    input  logic             dld,    // payload capture enable
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
`ifdef RVPIPE_PARITY_EN
    input  logic             p_in,
    output logic             p_q,
`endif
    output logic             v_q,
    output logic [WIDTH-1:0] d_q
);

    // Valid bit: flush wins over any load; idle valid entries hold.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)     v_q <= 1'b0;
        else if (flush) v_q <= 1'b0;
        else if (ld)    v_q <= v_in;
    end

    // Payload: captured only when the slot loads; a flush leaves it untouched.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)   d_q <= '0;
        else if (dld) d_q <= d_in;
    end

`ifdef RVPIPE_PARITY_EN
    // Parity travels with the payload under the same enable.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)   p_q <= 1'b0;
        else if (dld) p_q <= p_in;
    end
`endif

endmodule

// File: rtl/rvpipe_elastic.sv
// rvpipe_elastic: DEPTH-stage elastic valid/ready pipeline with bubble
// collapse, synchronous flush and occupancy count.
// Optional feature: define RVPIPE_PARITY_EN for per-stage parity and par_err.
module rvpipe_elastic
    import rvpipe_pkg::*;
#(
    parameter int WIDTH = 63,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    par_err
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    stage_ctl_t [DEPTH-1:0]      ctl;
    logic [DEPTH-1:0]            ld;
    logic [DEPTH-1:0]            dld;
    logic                        in_xfer;
    logic                        out_xfer;
`ifdef RVPIPE_PARITY_EN
    logic [DEPTH-1:0]            p;
`endif

    // Move chain: tail moves on out_ready, every other stage moves when the
    // next one is empty or moving. This is a combinational path from
    // out_ready all the way to in_ready.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ctl[k].v  = v[k];
            ctl[k].mv = 1'b0;
        end
        ctl[DEPTH-1].mv = out_ready;
        for (int k = DEPTH - 2; k >= 0; k--)
            ctl[k].mv = ~ctl[k+1].v | ctl[k+1].mv;
        for (int k = 0; k < DEPTH; k++) begin
            ld[k]  = ~ctl[k].v | ctl[k].mv;
            dld[k] = ld[k] & ~flush;
        end
        in_ready  = ~flush & ld[0];
        in_xfer   = in_valid & in_ready;
        // in_data is only captured on a real in-transfer
        dld[0]    = in_xfer;
        out_valid = v[DEPTH-1] & ~flush;
        out_xfer  = out_valid & out_ready;
    end

    assign out_data = d[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stg
        logic             v_in;
        logic [WIDTH-1:0] d_in;
`ifdef RVPIPE_PARITY_EN
        logic             p_in;
`endif
        if (k == 0) begin : g_head
            assign v_in = in_valid;
            assign d_in = in_data;
`ifdef RVPIPE_PARITY_EN
            assign p_in = ^in_data;
`endif
        end else begin : g_body
            assign v_in = v[k-1];
            assign d_in = d[k-1];
`ifdef RVPIPE_PARITY_EN
            assign p_in = p[k-1];
`endif
        end

        rvpipe_stage #(.WIDTH(WIDTH)) u_stg (
            .clk   (clk),
            .rst_l (rst_l),
            .flush (flush),
            .ld    (ld[k]),
            .dld   (dld[k]),
            .v_in  (v_in),
            .d_in  (d_in),
`ifdef RVPIPE_PARITY_EN
            .p_in  (p_in),
            .p_q   (p[k]),
`endif
            .v_q   (v[k]),
            .d_q   (d[k])
        );
    end

    // Occupancy: +1 per in-transfer, -1 per out-transfer, cleared on flush.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)     count <= '0;
        else if (flush) count <= '0;
        else            count <= count + CW'(in_xfer) - CW'(out_xfer);
    end

`ifdef RVPIPE_PARITY_EN
    assign par_err = out_valid & (^out_data ^ p[DEPTH-1]);
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvpipe_elastic.sv
// tb_rvpipe_elastic: directed bench for rvpipe_elastic. Instance u_a uses
// DEPTH=2, instance u_b uses DEPTH=4. Inputs change just after the falling
// edge; checks run 1ns later, well away from the rising edge.
// Define RVPIPE_PARITY_EN to also exercise the parity error path.
module tb_rvpipe_elastic;

    logic        clk = 1'b0;
    logic        rst_l;

    logic        fl_a, iv_a, ir_a, ov_a, ord_a, pe_a;
    logic [62:0] id_a, od_a;
    logic [1:0]  cnt_a;

    logic        fl_b, iv_b, ir_b, ov_b, ord_b, pe_b;
    logic [62:0] id_b, od_b;
    logic [2:0]  cnt_b;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    rvpipe_elastic #(.WIDTH(63), .DEPTH(2)) u_a (
        .clk(clk), .rst_l(rst_l), .flush(fl_a), .in_valid(iv_a), .in_ready(ir_a),
        .in_data(id_a), .out_valid(ov_a), .out_ready(ord_a), .out_data(od_a),
        .count(cnt_a), .par_err(pe_a)
    );

    rvpipe_elastic #(.WIDTH(63), .DEPTH(4)) u_b (
        .clk(clk), .rst_l(rst_l), .flush(fl_b), .in_valid(iv_b), .in_ready(ir_b),
        .in_data(id_b), .out_valid(ov_b), .out_ready(ord_b), .out_data(od_b),
        .count(cnt_b), .par_err(pe_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_l = 1'b0;
        fl_a = 0; iv_a = 0; id_a = '0; ord_a = 0;
        fl_b = 0; iv_b = 0; id_b = '0; ord_b = 0;
        #2;
        // reset state
        chk("rst_ov_a",  64'(ov_a),  64'd0);
        chk("rst_cnt_a", 64'(cnt_a), 64'd0);
        chk("rst_pe_a",  64'(pe_a),  64'd0);
        chk("rst_od_a",  64'(od_a),  64'd0);
        chk("rst_ov_b",  64'(ov_b),  64'd0);
        chk("rst_cnt_b", 64'(cnt_b), 64'd0);
        chk("rst_od_b",  64'(od_b),  64'd0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;

        // 1: DEPTH=2 stream 1..16 with out_ready=1
        exp_cnt = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            iv_a = (c < 16); id_a = 63'(c + 1); ord_a = 1'b1;
            #1;
            chk("t1_cnt",  64'(cnt_a), 64'(exp_cnt));
            chk("t1_irdy", 64'(ir_a),  64'd1);
            chk("t1_ov",   64'(ov_a),  64'(c >= 2));
            if (c >= 2) chk("t1_od", 64'(od_a), 64'(c - 1));
            chk("t1_perr", 64'(pe_a),  64'd0);
            exp_cnt = exp_cnt + ((c < 16) ? 1 : 0) - ((c >= 2) ? 1 : 0);
        end
        @(negedge clk);
        iv_a = 1'b0;
        #1;
        chk("t1_empty_ov",  64'(ov_a),  64'd0);
        chk("t1_empty_cnt", 64'(cnt_a), 64'd0);

        // 2: DEPTH=4 fill with out_ready=0, then drain
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            iv_b = 1'b1; id_b = 63'(8'hA0 + k); ord_b = 1'b0;
            #1;
            chk("t2_fill_irdy", 64'(ir_b),  64'd1);
            chk("t2_fill_cnt",  64'(cnt_b), 64'(k));
        end
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            iv_b = 1'b1; id_b = 63'h0A4;
            #1;
            chk("t2_full_irdy", 64'(ir_b),  64'd0);
            chk("t2_full_cnt",  64'(cnt_b), 64'd4);
            chk("t2_full_ov",   64'(ov_b),  64'd1);
            chk("t2_full_od",   64'(od_b),  64'h0A0);
            chk("t2_full_perr", 64'(pe_b),  64'd0);
`ifdef RVPIPE_PARITY_EN
            if (h == 1) begin
                logic [62:0] flip;
                flip = od_b ^ 63'd1;
                force u_b.out_data = flip;
                #1;
                chk("t6_perr_flip", 64'(pe_b), 64'd1);
                release u_b.out_data;
                #1;
                chk("t6_perr_clean", 64'(pe_b), 64'd0);
            end
`endif
        end
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            iv_b = 1'b0; ord_b = 1'b1;
            #1;
            chk("t2_drain_irdy", 64'(ir_b),  64'd1);
            chk("t2_drain_cnt",  64'(cnt_b), 64'(4 - r));
            chk("t2_drain_ov",   64'(ov_b),  64'(r < 4));
            if (r < 4) chk("t2_drain_od", 64'(od_b), 64'(8'hA0 + r));
        end

        // 3: A, gap, B into empty pipe with out_ready=0, then release
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ord_b = 1'b0;
            iv_b  = (c == 0) || (c == 2);
            id_b  = (c == 0) ? 63'h0A : 63'h0B;
        end
        @(negedge clk);
        iv_b = 1'b0; ord_b = 1'b1;
        #1;
        chk("t3_cnt",  64'(cnt_b), 64'd2);
        chk("t3_ovA",  64'(ov_b),  64'd1);
        chk("t3_odA",  64'(od_b),  64'h0A);
        @(negedge clk);
        #1;
        chk("t3_ovB",  64'(ov_b),  64'd1);
        chk("t3_odB",  64'(od_b),  64'h0B);
        @(negedge clk);
        #1;
        chk("t3_ov_end",  64'(ov_b),  64'd0);
        chk("t3_cnt_end", 64'(cnt_b), 64'd0);

        // 4: hold three items, pulse flush with in_valid=1
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ord_b = 1'b0;
            iv_b  = (c < 3);
            id_b  = 63'(8'hC1 + c);
        end
        @(negedge clk);
        #1;
        chk("t4_cnt3", 64'(cnt_b), 64'd3);
        chk("t4_od3",  64'(od_b),  64'h0C1);
        fl_b = 1'b1; iv_b = 1'b1; id_b = 63'h0DD;
        #1;
        chk("t4_fl_irdy", 64'(ir_b), 64'd0);
        chk("t4_fl_ov",   64'(ov_b), 64'd0);
        @(negedge clk);
        fl_b = 1'b0; iv_b = 1'b0;
        #1;
        chk("t4_post_cnt", 64'(cnt_b), 64'd0);
        chk("t4_post_ov",  64'(ov_b),  64'd0);
        chk("t4_post_od",  64'(od_b),  64'h0C1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ord_b = 1'b1;
            #1;
            chk("t4_drop_ov",  64'(ov_b),  64'd0);
            chk("t4_drop_cnt", 64'(cnt_b), 64'd0);
        end

        // 5: async reset mid-stream
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            iv_b = 1'b1; id_b = 63'(8'hE0 + c); ord_b = 1'b1;
            #1;
            chk("t5_irdy", 64'(ir_b), 64'd1);
        end
        @(negedge clk);
        iv_b = 1'b0;
        #1;
        chk("t5_pre_ov",  64'(ov_b),  64'd1);
        chk("t5_pre_od",  64'(od_b),  64'h0E0);
        chk("t5_pre_cnt", 64'(cnt_b), 64'd4);
        #1 rst_l = 1'b0;
        #1;
        chk("t5_rst_ov",  64'(ov_b),  64'd0);
        chk("t5_rst_cnt", 64'(cnt_b), 64'd0);
        #1 rst_l = 1'b1;
        for (int c = 5; c < 10; c++) begin
            @(negedge clk);
            iv_b = (c == 5); id_b = 63'h0F1;
            #1;
            if (c == 5) chk("t5_post_cnt", 64'(cnt_b), 64'd0);
            chk("t5_post_ov", 64'(ov_b), 64'(c == 9));
            if (c == 9) chk("t5_post_od", 64'(od_b), 64'h0F1);
            chk("t5_perr", 64'(pe_b), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
